// File: rtl/lt24_pio_bus_master.sv
// Avalon-MM initiator for single-register PIO slaves: commands (write/read/delay/nop)
// are queued in a small FIFO and executed strictly in order by one FSM.
module lt24_pio_bus_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int FIFO_DEPTH   = 8,
    parameter int READ_LATENCY = 0,
    parameter int DELAY_W      = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTF_W  = PTR_W + 1;
    localparam int LAT_W   = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int CNT_W   = (DELAY_W > LAT_W) ? DELAY_W : LAT_W;
    localparam int ENTRY_W = 2 + ADDR_W + DATA_W;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_DELAY = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RWAIT} state_t;

    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNTF_W-1:0]  count_reg;

    state_t             state_reg;
    logic [1:0]         cur_op_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               push, pop, fifo_empty, dispatch_ok;
    logic [ENTRY_W-1:0] head;
    logic [1:0]         head_op;
    logic [ADDR_W-1:0]  head_addr;
    logic [DATA_W-1:0]  head_data;
    logic [DELAY_W-1:0] head_delay;

    assign fifo_empty = (count_reg == '0);
    assign cmd_ready  = (count_reg != CNTF_W'(FIFO_DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign busy       = !fifo_empty || (state_reg != S_IDLE);

    assign head       = fifo_mem[rd_ptr_reg];
    assign head_op    = head[ENTRY_W-1 -: 2];
    assign head_addr  = head[DATA_W +: ADDR_W];
    assign head_data  = head[DATA_W-1:0];
    assign head_delay = head_data[DELAY_W-1:0];

    // The last cycle of a DELAY doubles as the dispatch cycle, so a DELAY of N
    // separates the surrounding bus cycles by N+2 clocks rather than N+3.
    assign dispatch_ok = (state_reg == S_IDLE) ||
                         (state_reg == S_EXEC && cur_op_reg == OP_DELAY && cnt_reg == '0);
    assign pop = dispatch_ok && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= {cmd_op, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + CNTF_W'(push) - CNTF_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            cur_op_reg   <= OP_NOP;
            cnt_reg      <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            m_address    <= '0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            m_writedata  <= '0;
        end else begin
            rsp_valid    <= 1'b0;
            m_chipselect <= 1'b0;
            m_write_n    <= 1'b1;
            if (pop) begin
                cur_op_reg <= head_op;
                state_reg  <= S_EXEC;
                case (head_op)
                    OP_WRITE: begin
                        m_chipselect <= 1'b1;
                        m_write_n    <= 1'b0;
                        m_address    <= head_addr;
                        m_writedata  <= head_data;
                    end
                    OP_READ: begin
                        m_chipselect <= 1'b1;
                        m_address    <= head_addr;
                    end
                    OP_DELAY: cnt_reg <= (head_delay == '0) ? '0 : CNT_W'(head_delay - 1'b1);
                    default: ;
                endcase
            end else begin
                case (state_reg)
                    S_EXEC: begin
                        case (cur_op_reg)
                            OP_READ: begin
                                if (READ_LATENCY == 0) begin
                                    rsp_data  <= m_readdata;
                                    rsp_valid <= 1'b1;
                                    state_reg <= S_IDLE;
                                end else begin
                                    cnt_reg   <= CNT_W'(READ_LATENCY - 1);
                                    state_reg <= S_RWAIT;
                                end
                            end
                            OP_DELAY: begin
                                if (cnt_reg == '0) state_reg <= S_IDLE;
                                else               cnt_reg   <= cnt_reg - 1'b1;
                            end
                            OP_WRITE, OP_NOP: state_reg <= S_IDLE;
                        endcase
                    end
                    S_RWAIT: begin
                        if (cnt_reg == '0) begin
                            rsp_data  <= m_readdata;
                            rsp_valid <= 1'b1;
                            state_reg <= S_IDLE;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lt24_pio_bus_master.sv
// Bench for lt24_pio_bus_master: directed and random command streams on a LAT=0 and a LAT=2
// instance, checked against a cycle-timeline model of command dispatch.
module tb_lt24_pio_bus_master;
    localparam int AW = 2;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n = 1'b0;
    logic          sel = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b11;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_data = '0;

    logic          rdy0, rdy1, rv0, rv1, busy0, busy1, cs0, cs1, wn0, wn1;
    logic [DW-1:0] rsd0, rsd1, wd0, wd1, rdata0, rdata1;
    logic [AW-1:0] a0, a1;

    lt24_pio_bus_master #(.READ_LATENCY(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid && !sel), .cmd_ready(rdy0),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rv0),
        .rsp_data(rsd0), .busy(busy0), .m_address(a0), .m_chipselect(cs0),
        .m_write_n(wn0), .m_writedata(wd0), .m_readdata(rdata0));

    lt24_pio_bus_master #(.READ_LATENCY(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid && sel), .cmd_ready(rdy1),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rv1),
        .rsp_data(rsd1), .busy(busy1), .m_address(a1), .m_chipselect(cs1),
        .m_write_n(wn1), .m_writedata(wd1), .m_readdata(rdata1));

    logic          cmd_ready, rsp_valid, busy, m_cs, m_wn;
    logic [DW-1:0] rsp_data, m_wd;
    logic [AW-1:0] m_a;
    assign cmd_ready = sel ? rdy1  : rdy0;
    assign rsp_valid = sel ? rv1   : rv0;
    assign rsp_data  = sel ? rsd1  : rsd0;
    assign busy      = sel ? busy1 : busy0;
    assign m_cs      = sel ? cs1   : cs0;
    assign m_wn      = sel ? wn1   : wn0;
    assign m_wd      = sel ? wd1   : wd0;
    assign m_a       = sel ? a1    : a0;

    // PIO slaves: combinational for instance 0, two-cycle read pipeline for instance 1
    logic [DW-1:0] smem0 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [DW-1:0] smem1 [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [DW-1:0] pipe1, pipe2;
    assign rdata0 = smem0[a0];
    assign rdata1 = pipe2;
    always @(posedge clk) begin
        if (cs0 && !wn0) smem0[a0] <= wd0;
        if (cs1 && !wn1) smem1[a1] <= wd1;
        pipe1 <= smem1[a1];
        pipe2 <= pipe1;
    end

    typedef struct {int t; logic wn; logic [AW-1:0] a; logic [DW-1:0] d;} bus_ev_t;
    typedef struct {int t; logic [DW-1:0] d;} rsp_ev_t;
    typedef struct {int t; logic [1:0] op; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;

    bus_ev_t obs_bus[$], exp_bus[$];
    rsp_ev_t obs_rsp[$], exp_rsp[$];
    cmd_t    cmds[$];
    bit      busy_hist [0:32767];
    logic [DW-1:0] mm [2][4];
    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_cs) obs_bus.push_back('{cyc, m_wn, m_a, m_wd});
            if (rsp_valid) obs_rsp.push_back('{cyc, rsp_data});
            busy_hist[cyc] <= busy;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; reports the accept cycle and cycles spent stalled.
    task automatic push(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int gap, output int t_acc, output int waited);
        repeat (gap) begin @(posedge clk); #1; end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        waited = 0;
        while (!cmd_ready && waited < 2000) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!cmd_ready) check("push_timeout", 1, 0);
        t_acc = cyc;
        cmds.push_back('{cyc, op, a, d});
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Timeline model: a command popped at cycle d has its bus cycle at d+1; the next
    // command may pop at the earliest cycle listed per op below.
    task automatic run_check(input int s, input int lat);
        int d_free, d, e, n, end_t;
        logic [DW-1:0] last_rsp;
        bit have_rsp;
        d_free = 0; end_t = 0; have_rsp = 0; last_rsp = '0;
        exp_bus.delete(); exp_rsp.delete();
        foreach (cmds[i]) begin
            d = (cmds[i].t + 1 > d_free) ? cmds[i].t + 1 : d_free;
            e = d + 1;
            case (cmds[i].op)
                2'b00: begin
                    exp_bus.push_back('{e, 1'b0, cmds[i].a, cmds[i].d});
                    mm[s][cmds[i].a] = cmds[i].d;
                    d_free = d + 2; end_t = d + 2;
                end
                2'b01: begin
                    exp_bus.push_back('{e, 1'b1, cmds[i].a, '0});
                    exp_rsp.push_back('{e + 1 + lat, mm[s][cmds[i].a]});
                    last_rsp = mm[s][cmds[i].a]; have_rsp = 1;
                    d_free = d + 2 + lat; end_t = d + 2 + lat;
                end
                2'b10: begin
                    n = int'(cmds[i].d[15:0]);
                    if (n == 0) n = 1;
                    d_free = d + n; end_t = d + n + 1;
                end
                default: begin d_free = d + 2; end_t = d + 2; end
            endcase
        end
        while (cyc < end_t + 3) begin @(posedge clk); #1; end
        check("bus_count", obs_bus.size(), exp_bus.size());
        for (int i = 0; i < exp_bus.size() && i < obs_bus.size(); i++) begin
            check("bus_time", obs_bus[i].t, exp_bus[i].t);
            check("bus_write_n", obs_bus[i].wn, exp_bus[i].wn);
            check("bus_addr", obs_bus[i].a, exp_bus[i].a);
            if (!exp_bus[i].wn) check("bus_wdata", obs_bus[i].d, exp_bus[i].d);
        end
        check("rsp_count", obs_rsp.size(), exp_rsp.size());
        for (int i = 0; i < exp_rsp.size() && i < obs_rsp.size(); i++) begin
            check("rsp_time", obs_rsp[i].t, exp_rsp[i].t);
            check("rsp_data", obs_rsp[i].d, exp_rsp[i].d);
        end
        if (have_rsp) check("rsp_data_held", rsp_data, last_rsp);
        check("busy_before_end", busy_hist[end_t - 1], 1);
        check("busy_at_end", busy_hist[end_t], 0);
        $display("phase inst=%0d cmds=%0d bus=%0d rsp=%0d end=%0d",
                 s, cmds.size(), exp_bus.size(), exp_rsp.size(), end_t);
        obs_bus.delete(); obs_rsp.delete(); cmds.delete();
    endtask

    task automatic random_cmds(input int count);
        int r, ta, w;
        logic [DW-1:0] d;
        logic [1:0] op;
        for (int i = 0; i < count; i++) begin
            r = $urandom_range(0, 9);
            d = $urandom();
            if (r < 4)      op = 2'b00;
            else if (r < 7) op = 2'b01;
            else if (r < 9) op = 2'b10;
            else            op = 2'b11;
            if (op == 2'b10) d[15:0] = 16'($urandom_range(0, 6));
            push(op, AW'($urandom_range(0, 3)), d, $urandom_range(0, 3), ta, w);
        end
    endtask

    initial begin
        int ta, w, t0;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 4; i++) mm[s][i] = 32'h11 * (i + 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_cs", m_cs, 0);
        check("rst_write_n", m_wn, 1);
        check("rst_addr", m_a, 0);
        check("rst_wdata", m_wd, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_busy_lat2", busy1, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // single write, then a read of the same register
        push(2'b00, 2'd0, 32'h1, 0, ta, w);
        run_check(0, 0);
        push(2'b01, 2'd0, 32'h0, 0, ta, w);
        run_check(0, 0);

        // write / DELAY 100 / write back to back, then DELAY 0 and DELAY 1
        push(2'b00, 2'd0, 32'hA0, 0, ta, w);
        push(2'b10, 2'd0, 32'hFFFF_0064, 0, ta, w);
        push(2'b00, 2'd1, 32'hA1, 0, ta, w);
        push(2'b10, 2'd0, 32'h0, 0, ta, w);
        push(2'b00, 2'd2, 32'hA2, 0, ta, w);
        push(2'b10, 2'd0, 32'h1, 0, ta, w);
        push(2'b00, 2'd3, 32'hA3, 0, ta, w);
        push(2'b11, 2'd0, 32'h0, 0, ta, w);
        push(2'b01, 2'd1, 32'h0, 0, ta, w);
        run_check(0, 0);

        // fill the FIFO behind a DELAY 60: eight accepted at once, ninth after first pop
        push(2'b10, 2'd0, 32'd60, 0, t0, w);
        for (int i = 0; i < 8; i++) begin
            push(2'b00, AW'(i), 32'hB0 + 32'(i), 0, ta, w);
            check("fill_no_stall", w, 0);
        end
        check("full_cmd_ready", cmd_ready, 0);
        push(2'b01, 2'd3, 32'h0, 0, ta, w);
        check("ninth_accept_cycle", ta, t0 + 62);
        run_check(0, 0);

        random_cmds(30);
        run_check(0, 0);

        // read latency 2 instance
        sel = 1'b1;
        @(posedge clk); #1;
        push(2'b01, 2'd2, 32'h0, 0, ta, w);
        push(2'b00, 2'd2, 32'h5A5A, 0, ta, w);
        push(2'b01, 2'd2, 32'h0, 0, ta, w);
        run_check(1, 2);
        random_cmds(30);
        run_check(1, 2);

        // reset during a DELAY 50 with three commands queued behind it
        sel = 1'b0;
        @(posedge clk); #1;
        push(2'b10, 2'd0, 32'd50, 0, ta, w);
        push(2'b00, 2'd1, 32'hC1, 0, ta, w);
        push(2'b00, 2'd2, 32'hC2, 0, ta, w);
        push(2'b01, 2'd3, 32'h0, 0, ta, w);
        repeat (5) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_cs", m_cs, 0);
        check("arst_write_n", m_wn, 1);
        check("arst_addr", m_a, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        check("arst_rsp_data", rsp_data, 0);
        obs_bus.delete(); obs_rsp.delete(); cmds.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("post_rst_bus_cycles", obs_bus.size(), 0);
        check("post_rst_rsp", obs_rsp.size(), 0);
        check("post_rst_busy", busy, 0);

        // still functional after the abort
        push(2'b00, 2'd1, 32'hD1, 0, ta, w);
        push(2'b01, 2'd1, 32'h0, 1, ta, w);
        run_check(0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
